// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clkdiv_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } ch_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_BUSY,
        D_DONE
    } div_state_e;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/clkdiv_period_calc.sv
// Restoring radix-2 divider: quotient = dividend / divisor after W iterations.
// done is a one-cycle pulse; quotient holds its value until the next start.
module clkdiv_period_calc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int STEP_W = $clog2(W + 1);

    logic [W-1:0]      rem;
    logic [W-1:0]      dsr;
    logic [STEP_W-1:0] steps;
    logic              running;
    logic [W:0]        rem_shift;
    logic [W:0]        rem_sub;

    // The dividend is shifted out of the quotient register as quotient bits enter.
    assign rem_shift = {rem, quotient[W-1]};
    assign rem_sub   = rem_shift - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (reset) begin
            rem      <= '0;
            dsr      <= '0;
            quotient <= '0;
            steps    <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                dsr      <= divisor;
                quotient <= dividend;
                steps    <= STEP_W'(W);
                running  <= 1'b1;
            end else if (running) begin
                if (rem_shift >= {1'b0, dsr}) begin
                    rem      <= rem_sub[W-1:0];
                    quotient <= {quotient[W-2:0], 1'b1};
                end else begin
                    rem      <= rem_shift[W-1:0];
                    quotient <= {quotient[W-2:0], 1'b0};
                end
                steps <= steps - STEP_W'(1);
                if (steps == STEP_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH square-wave generators whose periods (BASE_SPEED/speed) come from one shared divider.
// Define MULTI_CLOCK_DIVIDER_TICK_EN to add the per-channel rising-edge tick output.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int BASE_SPEED = 50_000_000,
    parameter int NUM_CH     = 4,
    parameter int SPEED_W    = 20,
    parameter int CNT_W      = $clog2(BASE_SPEED) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*SPEED_W-1:0] speed,
    input  logic [NUM_CH-1:0]         ch_en,
    output logic [NUM_CH-1:0]         out_clk,
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
    output logic [NUM_CH-1:0]         tick,
`endif
    output logic                      busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] BASE_DIV = CNT_W'(BASE_SPEED);

    logic [SPEED_W-1:0] speed_ch [NUM_CH];
    logic [SPEED_W-1:0] req_q    [NUM_CH];
    logic [NUM_CH-1:0]  dirty;
    logic [NUM_CH-1:0]  dirty_eff;
    logic [NUM_CH-1:0]  dirty_n;
    logic [NUM_CH-1:0]  pend_wr;

    div_state_e         div_state;
    div_state_e         div_state_n;
    logic [CH_W-1:0]    last_ch;
    logic [CH_W-1:0]    cur_ch;
    logic [CH_W-1:0]    grant_ch;
    logic               grant_found;
    logic               issue;
    logic [SPEED_W-1:0] issue_speed;
    logic [CNT_W-1:0]   result;

    logic               calc_start;
    logic               calc_done;
    logic [CNT_W-1:0]   calc_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            speed_ch[i]  = speed[i*SPEED_W +: SPEED_W];
            dirty_eff[i] = dirty[i] | (speed_ch[i] != req_q[i]);
        end
    end

    // Round-robin: first dirty channel above the last served one, then wrap to the bottom.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_found && dirty_eff[i] && (CH_W'(i) > last_ch)) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_found && dirty_eff[i] && (CH_W'(i) <= last_ch)) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'(i);
            end
        end
    end

    // A new division may start in the cycle the previous result is being posted.
    assign issue       = grant_found && ((div_state == D_IDLE) || (div_state == D_DONE));
    assign issue_speed = speed_ch[grant_ch];
    assign calc_start  = issue && (issue_speed != '0);

    always_comb begin
        div_state_n = div_state;
        case (div_state)
            D_IDLE:  div_state_n = D_IDLE;
            D_BUSY:  if (calc_done) div_state_n = D_DONE;
            D_DONE:  div_state_n = D_IDLE;
            default: div_state_n = D_IDLE;
        endcase
        if (issue) begin
            div_state_n = (issue_speed == '0) ? D_DONE : D_BUSY;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dirty_n[i] = dirty_eff[i] & ~(issue && (grant_ch == CH_W'(i)));
            pend_wr[i] = (div_state == D_DONE) && (cur_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_state <= D_IDLE;
            dirty     <= '1;
            last_ch   <= CH_W'(NUM_CH - 1);
            cur_ch    <= '0;
            result    <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                req_q[i] <= '0;
            end
        end else begin
            div_state <= div_state_n;
            dirty     <= dirty_n;
            busy      <= (div_state_n != D_IDLE) || (dirty_n != '0);
            if (issue) begin
                req_q[grant_ch] <= issue_speed;
                cur_ch          <= grant_ch;
                last_ch         <= grant_ch;
                if (issue_speed == '0) begin
                    result <= '0;
                end
            end
            if ((div_state == D_BUSY) && calc_done) begin
                result <= (calc_q < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : calc_q;
            end
        end
    end

    clkdiv_period_calc #(
        .W(CNT_W)
    ) u_period_calc (
        .clk      (clk),
        .reset    (reset),
        .start    (calc_start),
        .dividend (BASE_DIV),
        .divisor  (CNT_W'(issue_speed)),
        .done     (calc_done),
        .quotient (calc_q)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_e        state;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] pend_period;
        logic             pend_valid;
        logic             out_q;
        logic             eff_valid;
        logic [CNT_W-1:0] eff_period;
        logic [CNT_W-1:0] half;

        // A result posted this cycle counts as pending so it can load at a coincident wrap.
        assign eff_valid  = pend_valid | pend_wr[g];
        assign eff_period = pend_wr[g] ? result : pend_period;
        assign half       = period >> 1;
        assign out_clk[g] = out_q;

`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
        logic tick_q;
        assign tick[g] = tick_q;
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                state       <= IDLE;
                period      <= '0;
                cnt         <= '0;
                pend_period <= '0;
                pend_valid  <= 1'b0;
                out_q       <= 1'b0;
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
                tick_q      <= 1'b0;
`endif
            end else begin
                if (pend_wr[g]) begin
                    pend_period <= result;
                    pend_valid  <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        out_q <= 1'b0;
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
                        tick_q <= 1'b0;
`endif
                        if (ch_en[g]) begin
                            if (eff_valid) begin
                                period     <= eff_period;
                                pend_valid <= 1'b0;
                            end
                            if (eff_valid ? (eff_period != '0) : (period != '0)) begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (!ch_en[g]) begin
                            state <= IDLE;
                            cnt   <= '0;
                            out_q <= 1'b0;
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
                            tick_q <= 1'b0;
`endif
                        end else begin
                            out_q <= (cnt >= half);
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
                            tick_q <= (cnt == half);
`endif
                            if (cnt == period - CNT_W'(1)) begin
                                cnt <= '0;
                                if (eff_valid) begin
                                    period     <= eff_period;
                                    pend_valid <= 1'b0;
                                    if (eff_period == '0) begin
                                        state <= IDLE;
                                    end
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider with BASE_SPEED=100, NUM_CH=2, SPEED_W=8 (CNT_W=8).
module tb_multi_clock_divider;

    logic        clk;
    logic        reset;
    logic [15:0] speed;
    logic [1:0]  ch_en;
    logic [1:0]  out_clk;
    logic        busy;
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
    logic [1:0]  tick;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int hi_a [4];
    int lo_a [4];

    multi_clock_divider #(
        .BASE_SPEED (100),
        .NUM_CH     (2),
        .SPEED_W    (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .speed   (speed),
        .ch_en   (ch_en),
        .out_clk (out_clk),
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
        .tick    (tick),
`endif
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_busy_low(output bit ok);
        int g;
        g = 0;
        repeat (2) @(negedge clk);
        while (busy !== 1'b0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        ok = (busy === 1'b0);
    endtask

    // Records n consecutive periods of one channel, each starting at a rising edge.
    task automatic measure(input int ch, input int n);
        int g;
        g = 0;
        for (int p = 0; p < 4; p++) begin
            hi_a[p] = -1;
            lo_a[p] = -1;
        end
        while (out_clk[ch] !== 1'b0 && g < 400) begin @(negedge clk); g++; end
        while (out_clk[ch] !== 1'b1 && g < 400) begin @(negedge clk); g++; end
        for (int p = 0; p < n; p++) begin
            hi_a[p] = 0;
            while (out_clk[ch] === 1'b1 && g < 400) begin hi_a[p]++; @(negedge clk); g++; end
            lo_a[p] = 0;
            while (out_clk[ch] === 1'b0 && g < 400) begin lo_a[p]++; @(negedge clk); g++; end
            if (g >= 400) begin
                hi_a[p] = -1;
                lo_a[p] = -1;
            end
        end
    endtask

    initial begin
        bit ok;
        int cnt_hi;
        int busy_cnt;
        int first0;
        int first1;
        int g;

        // Reset with channel 0 at 10 Hz, channel 1 disabled
        reset = 1'b1;
        speed = {8'd0, 8'd10};
        ch_en = 2'b01;
        repeat (3) @(negedge clk);
        check("reset_out_clk", 32'(out_clk), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
        check("reset_tick", 32'(tick), 32'd0);
`endif
        reset = 1'b0;

        // 1: period 10 -> 5 low / 5 high; channel 1 silent
        wait_busy_low(ok);
        check("t1_settle", 32'(ok), 32'd1);
        measure(0, 2);
        check("t1_hi0", hi_a[0], 5);
        check("t1_lo0", lo_a[0], 5);
        check("t1_hi1", hi_a[1], 5);
        check("t1_lo1", lo_a[1], 5);
        cnt_hi = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_clk[1] !== 1'b0) cnt_hi++;
        end
        check("t1_ch1_quiet", cnt_hi, 0);

        // 2: 3 Hz -> period 33 -> 16 low / 17 high
        speed[7:0] = 8'd3;
        wait_busy_low(ok);
        check("t2_settle", 32'(ok), 32'd1);
        measure(0, 2);
        check("t2_hi", hi_a[1], 17);
        check("t2_lo", lo_a[1], 16);

        // 3: back to 10 Hz, then switch to 20 Hz at cnt=2 of a period
        speed[7:0] = 8'd10;
        wait_busy_low(ok);
        check("t3_settle", 32'(ok), 32'd1);
        measure(0, 2);
        check("t3_pre_hi", hi_a[1], 5);
        g = 0;
        while (out_clk[0] !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        while (out_clk[0] !== 1'b0 && g < 100) begin @(negedge clk); g++; end
        check("t3_sync", 32'(g < 100), 32'd1);
        @(negedge clk);
        speed[7:0] = 8'd20;
        measure(0, 3);
        check("t3_cur_hi", hi_a[0], 5);
        check("t3_cur_lo", lo_a[0], 5);
        check("t3_wrap_hi", hi_a[1], 5);
        check("t3_wrap_lo", lo_a[1], 2);
        check("t3_new_hi", hi_a[2], 3);
        check("t3_new_lo", lo_a[2], 2);

        // 4: 80 Hz clamps to period 2; 0 Hz stops the channel
        speed[7:0] = 8'd80;
        wait_busy_low(ok);
        check("t4_settle", 32'(ok), 32'd1);
        measure(0, 2);
        check("t4_clamp_hi", hi_a[1], 1);
        check("t4_clamp_lo", lo_a[1], 1);
        speed[7:0] = 8'd0;
        wait_busy_low(ok);
        check("t4_stop_settle", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        cnt_hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_clk[0] !== 1'b0) cnt_hi++;
        end
        check("t4_stopped", cnt_hi, 0);

        // 5: both channels change together; channel 1 is next in round-robin order
        check("t5_busy_before", 32'(busy), 32'd0);
        ch_en = 2'b11;
        speed = {8'd25, 8'd10};
        busy_cnt = 0;
        first0 = -1;
        first1 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (first0 < 0 && out_clk[0] === 1'b1) first0 = k;
            if (first1 < 0 && out_clk[1] === 1'b1) first1 = k;
        end
        check("t5_busy_cycles", busy_cnt, 20);
        check("t5_ch1_first_rise", first1, 14);
        check("t5_ch0_first_rise", first0, 27);
        measure(0, 2);
        check("t5_ch0_hi", hi_a[1], 5);
        check("t5_ch0_lo", lo_a[1], 5);
        measure(1, 2);
        check("t5_ch1_hi", hi_a[1], 2);
        check("t5_ch1_lo", lo_a[1], 2);

        // 6: reset during a division and during channel 0's high phase
        g = 0;
        while (out_clk[0] !== 1'b0 && g < 100) begin @(negedge clk); g++; end
        while (out_clk[0] !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        speed[7:0] = 8'd20;
        repeat (2) @(negedge clk);
        check("t6_busy_mid_div", 32'(busy), 32'd1);
        check("t6_high_before", 32'(out_clk[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_out_clk", 32'(out_clk), 32'd0);
        check("t6_reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_busy_low(ok);
        check("t6_settle", 32'(ok), 32'd1);
        measure(0, 2);
        check("t6_ch0_hi", hi_a[1], 3);
        check("t6_ch0_lo", lo_a[1], 2);
        measure(1, 2);
        check("t6_ch1_hi", hi_a[1], 2);
        check("t6_ch1_lo", lo_a[1], 2);

`ifdef MULTI_CLOCK_DIVIDER_TICK_EN
        begin
            logic prev;
            int   ticks;
            int   bad;
            ticks = 0;
            bad   = 0;
            @(negedge clk);
            prev = out_clk[0];
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (tick[0] === 1'b1) ticks++;
                if (tick[0] !== (out_clk[0] & ~prev)) bad++;
                prev = out_clk[0];
            end
            check("t6_tick_align", bad, 0);
            check("t6_tick_count", ticks, 6);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
